// File: rtl/int_ctrl_pkg.sv
// Shared constants for the interrupt controller: FSM states, CSR addresses,
// trap instruction encodings, cause codes and mstatus update helpers.
package int_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MEPC    = 3'd1,
        S_MSTATUS = 3'd2,
        S_MCAUSE  = 3'd3,
        S_MRET    = 3'd4,
        S_ASSERT  = 3'd5
    } state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [31:0] CAUSE_ECALL_M      = 32'd11;
    localparam logic [31:0] CAUSE_BREAKPOINT   = 32'd3;
    localparam logic [31:0] CAUSE_EXT_IRQ_BASE = 32'h8000_0010;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int IRQ_IDX_W    = 4;

    // Trap entry: stash MIE into MPIE and mask further interrupts.
    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] s);
        logic [31:0] r;
        r               = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        return r;
    endfunction

    // Trap return: restore MIE from MPIE and set MPIE.
    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] s);
        logic [31:0] r;
        r               = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder over the external interrupt lines.
// Purely combinational; no backpressure.
module int_prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int INT_NUM = 8
) (
    input  logic [INT_NUM-1:0]   int_flag,
    output logic [IRQ_IDX_W-1:0] idx,
    output logic                 vld
);

    always_comb begin
        idx = '0;
        vld = 1'b0;
        // Scan high to low so the lowest set line is the last assignment.
        for (int i = INT_NUM - 1; i >= 0; i--) begin
            if (int_flag[i]) begin
                idx = IRQ_IDX_W'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Trap/interrupt sequencer: writes mepc/mstatus/mcause then redirects the PC;
// trap redirect at N+4, mret at N+2; no backpressure, triggers outside IDLE are dropped.
// Optional: INT_CTRL_SYNC_EXC_EN enables ecall/ebreak handling.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int INT_NUM = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INT_NUM-1:0] int_flag,
    input  logic [31:0]        inst,
    input  logic [31:0]        inst_addr,
    input  logic               jump_flag,
    input  logic [31:0]        jump_addr,
    input  logic               hold_ex,
    input  logic [31:0]        csr_mtvec,
    input  logic [31:0]        csr_mepc,
    input  logic [31:0]        csr_mstatus,
    output logic               clear_flag_int,
    output logic               int_assert,
    output logic [31:0]        int_addr,
    output logic               csr_we,
    output logic [11:0]        csr_waddr,
    output logic [31:0]        csr_wdata
);

    state_t                 state;
    logic [31:0]            mepc_q;
    logic [31:0]            mcause_q;
    logic                   ret_q;

    logic [IRQ_IDX_W-1:0]   irq_idx;
    logic                   irq_vld;
    logic                   sync_trig;
    logic                   is_ebreak;
    logic                   mret_trig;
    logic                   async_trig;
    logic                   trig;

    int_prio_enc #(
        .INT_NUM (INT_NUM)
    ) u_prio_enc (
        .int_flag (int_flag),
        .idx      (irq_idx),
        .vld      (irq_vld)
    );

    always_comb begin
        sync_trig = 1'b0;
        is_ebreak = 1'b0;
`ifdef INT_CTRL_SYNC_EXC_EN
        sync_trig = (inst == INST_ECALL) || (inst == INST_EBREAK);
        is_ebreak = (inst == INST_EBREAK);
`endif
        mret_trig  = !sync_trig && (inst == INST_MRET);
        async_trig = !sync_trig && !mret_trig && irq_vld
                     && csr_mstatus[MSTATUS_MIE] && !hold_ex;
        trig       = (state == S_IDLE) && (sync_trig || mret_trig || async_trig);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            mepc_q   <= '0;
            mcause_q <= '0;
            ret_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sync_trig) begin
                        mepc_q   <= inst_addr + 32'd4;
                        mcause_q <= is_ebreak ? CAUSE_BREAKPOINT : CAUSE_ECALL_M;
                        ret_q    <= 1'b0;
                        state    <= S_MEPC;
                    end else if (mret_trig) begin
                        mepc_q   <= csr_mepc;
                        ret_q    <= 1'b1;
                        state    <= S_MRET;
                    end else if (async_trig) begin
                        // A taken branch in execute means the next PC is its target.
                        mepc_q   <= jump_flag ? jump_addr : inst_addr;
                        mcause_q <= CAUSE_EXT_IRQ_BASE + 32'(irq_idx);
                        ret_q    <= 1'b0;
                        state    <= S_MEPC;
                    end
                end
                S_MEPC:    state <= S_MSTATUS;
                S_MSTATUS: state <= S_MCAUSE;
                S_MCAUSE:  state <= S_ASSERT;
                S_MRET:    state <= S_ASSERT;
                S_ASSERT:  state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode the registered state; only the IDLE flush looks at live inputs.
    always_comb begin
        clear_flag_int = 1'b0;
        int_assert     = 1'b0;
        int_addr       = '0;
        csr_we         = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        case (state)
            S_IDLE: begin
                clear_flag_int = trig && !rst;
            end
            S_MEPC: begin
                clear_flag_int = 1'b1;
                csr_we         = 1'b1;
                csr_waddr      = CSR_MEPC;
                csr_wdata      = mepc_q;
            end
            S_MSTATUS: begin
                clear_flag_int = 1'b1;
                csr_we         = 1'b1;
                csr_waddr      = CSR_MSTATUS;
                csr_wdata      = mstatus_on_trap(csr_mstatus);
            end
            S_MCAUSE: begin
                clear_flag_int = 1'b1;
                csr_we         = 1'b1;
                csr_waddr      = CSR_MCAUSE;
                csr_wdata      = mcause_q;
            end
            S_MRET: begin
                clear_flag_int = 1'b1;
                csr_we         = 1'b1;
                csr_waddr      = CSR_MSTATUS;
                csr_wdata      = mstatus_on_mret(csr_mstatus);
            end
            S_ASSERT: begin
                int_assert = 1'b1;
                int_addr   = ret_q ? mepc_q : csr_mtvec;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: trap, mret, masking, jump target and mid-sequence reset.
module tb_int_ctrl;

    localparam int INT_NUM = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic               clk = 1'b0;
    logic               rst;
    logic [INT_NUM-1:0] int_flag;
    logic [31:0]        inst;
    logic [31:0]        inst_addr;
    logic               jump_flag;
    logic [31:0]        jump_addr;
    logic               hold_ex;
    logic [31:0]        csr_mtvec;
    logic [31:0]        csr_mepc;
    logic [31:0]        csr_mstatus;
    logic               clear_flag_int;
    logic               int_assert;
    logic [31:0]        int_addr;
    logic               csr_we;
    logic [11:0]        csr_waddr;
    logic [31:0]        csr_wdata;

    int checks   = 0;
    int failures = 0;

    int_ctrl #(.INT_NUM(INT_NUM)) dut (
        .clk            (clk),
        .rst            (rst),
        .int_flag       (int_flag),
        .inst           (inst),
        .inst_addr      (inst_addr),
        .jump_flag      (jump_flag),
        .jump_addr      (jump_addr),
        .hold_ex        (hold_ex),
        .csr_mtvec      (csr_mtvec),
        .csr_mepc       (csr_mepc),
        .csr_mstatus    (csr_mstatus),
        .clear_flag_int (clear_flag_int),
        .int_assert     (int_assert),
        .int_addr       (int_addr),
        .csr_we         (csr_we),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic clr, input logic ia,
                              input logic [31:0] iaddr, input logic we,
                              input logic [11:0] waddr, input logic [31:0] wdata);
        check_eq({tag, ".clear"},  32'(clear_flag_int), 32'(clr));
        check_eq({tag, ".assert"}, 32'(int_assert),     32'(ia));
        check_eq({tag, ".iaddr"},  int_addr,            iaddr);
        check_eq({tag, ".we"},     32'(csr_we),         32'(we));
        check_eq({tag, ".waddr"},  32'(csr_waddr),      32'(waddr));
        check_eq({tag, ".wdata"},  csr_wdata,           wdata);
    endtask

    // Check at the falling edge, then advance to just after the next rising edge.
    task automatic expect_cyc(input string tag, input logic clr, input logic ia,
                              input logic [31:0] iaddr, input logic we,
                              input logic [11:0] waddr, input logic [31:0] wdata);
        @(negedge clk);
        check_outs(tag, clr, ia, iaddr, we, waddr, wdata);
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        inst      = NOP;
        int_flag  = '0;
        jump_flag = 1'b0;
        hold_ex   = 1'b0;
    endtask

    // Trap body after the trigger cycle, with mstatus=0x8 and mtvec=0x80 held.
    task automatic run_trap(input string tag, input logic [31:0] mepc, input logic [31:0] mcause);
        expect_cyc({tag, ".mepc"},    1'b1, 1'b0, 32'h0,  1'b1, 12'h341, mepc);
        expect_cyc({tag, ".mstatus"}, 1'b1, 1'b0, 32'h0,  1'b1, 12'h300, 32'h80);
        expect_cyc({tag, ".mcause"},  1'b1, 1'b0, 32'h0,  1'b1, 12'h342, mcause);
        expect_cyc({tag, ".assert"},  1'b0, 1'b1, 32'h80, 1'b0, 12'h0,   32'h0);
    endtask

    initial begin
        rst         = 1'b1;
        quiet();
        inst_addr   = 32'h0;
        jump_addr   = 32'h0;
        csr_mtvec   = 32'h80;
        csr_mepc    = 32'h0;
        csr_mstatus = 32'h0;
        int_flag    = 8'h01;
        expect_cyc("reset", 1'b0, 1'b0, 32'h0, 1'b0, 12'h0, 32'h0);
        rst = 1'b0;
        quiet();
        expect_cyc("idle", 1'b0, 1'b0, 32'h0, 1'b0, 12'h0, 32'h0);

        // Async interrupt on line 2.
        csr_mstatus = 32'h8;
        int_flag    = 8'h04;
        inst_addr   = 32'h100;
        expect_cyc("irq2.trig", 1'b1, 1'b0, 32'h0, 1'b0, 12'h0, 32'h0);
        quiet();
        run_trap("irq2", 32'h100, 32'h8000_0012);
        expect_cyc("irq2.idle", 1'b0, 1'b0, 32'h0, 1'b0, 12'h0, 32'h0);

        // ecall with a simultaneous async request on line 0.
        inst      = 32'h0000_0073;
        inst_addr = 32'h200;
        int_flag  = 8'h01;
        expect_cyc("ecall.trig", 1'b1, 1'b0, 32'h0, 1'b0, 12'h0, 32'h0);
        inst = NOP;
`ifdef INT_CTRL_SYNC_EXC_EN
        run_trap("ecall", 32'h204, 32'd11);
        expect_cyc("defer.trig", 1'b1, 1'b0, 32'h0, 1'b0, 12'h0, 32'h0);
        quiet();
        run_trap("defer", 32'h200, 32'h8000_0010);
`else
        quiet();
        run_trap("ecall_off", 32'h200, 32'h8000_0010);
`endif
        expect_cyc("ecall.idle", 1'b0, 1'b0, 32'h0, 1'b0, 12'h0, 32'h0);

        // mret restores MIE from MPIE and returns to csr_mepc.
        csr_mepc    = 32'h204;
        csr_mstatus = 32'h80;
        inst        = 32'h3020_0073;
        expect_cyc("mret.trig", 1'b1, 1'b0, 32'h0, 1'b0, 12'h0, 32'h0);
        quiet();
        expect_cyc("mret.write",  1'b1, 1'b0, 32'h0,   1'b1, 12'h300, 32'h88);
        expect_cyc("mret.assert", 1'b0, 1'b1, 32'h204, 1'b0, 12'h0,   32'h0);
        expect_cyc("mret.idle",   1'b0, 1'b0, 32'h0,   1'b0, 12'h0,   32'h0);

        // Masked by mstatus.MIE, then by hold_ex.
        csr_mstatus = 32'h0;
        int_flag    = 8'h01;
        expect_cyc("mie_off.0", 1'b0, 1'b0, 32'h0, 1'b0, 12'h0, 32'h0);
        expect_cyc("mie_off.1", 1'b0, 1'b0, 32'h0, 1'b0, 12'h0, 32'h0);
        csr_mstatus = 32'h8;
        hold_ex     = 1'b1;
        expect_cyc("hold.0", 1'b0, 1'b0, 32'h0, 1'b0, 12'h0, 32'h0);
        expect_cyc("hold.1", 1'b0, 1'b0, 32'h0, 1'b0, 12'h0, 32'h0);
        quiet();

        // Branch taken: mepc is the jump target; lowest of lines 3 and 5 wins.
        int_flag  = 8'h28;
        jump_flag = 1'b1;
        jump_addr = 32'h300;
        inst_addr = 32'h180;
        expect_cyc("jump.trig", 1'b1, 1'b0, 32'h0, 1'b0, 12'h0, 32'h0);
        quiet();
        run_trap("jump", 32'h300, 32'h8000_0013);

        // Highest line alone.
        int_flag  = 8'h80;
        inst_addr = 32'h1c0;
        expect_cyc("irq7.trig", 1'b1, 1'b0, 32'h0, 1'b0, 12'h0, 32'h0);
        quiet();
        run_trap("irq7", 32'h1c0, 32'h8000_0017);

        // Reset while in MSTATUS.
        int_flag  = 8'h01;
        inst_addr = 32'h40;
        expect_cyc("rstmid.trig", 1'b1, 1'b0, 32'h0, 1'b0, 12'h0, 32'h0);
        quiet();
        expect_cyc("rstmid.mepc", 1'b1, 1'b0, 32'h0, 1'b1, 12'h341, 32'h40);
        #2;
        check_outs("rstmid.pre", 1'b1, 1'b0, 32'h0, 1'b1, 12'h300, 32'h80);
        rst = 1'b1;
        #1;
        check_outs("rstmid.now", 1'b0, 1'b0, 32'h0, 1'b0, 12'h0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_cyc("rstmid.after", 1'b0, 1'b0, 32'h0, 1'b0, 12'h0, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
